// File: rtl/cmd_unpack_pkg.sv
//------------------------------------------------------------------------------
// Module  : cmd_unpack_pkg
// Brief   : Shared widths, default frame delimiters and frame FSM encoding.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cmd_unpack_pkg;

  localparam int c_WORD_W = 16;
  localparam int c_CMD_W  = 32;
  localparam int c_CNT_W  = $clog2(c_WORD_W);

  // Delimiters are shared with the transmit-side packer
  localparam logic [c_WORD_W-1:0] c_DEF_HDR = 16'h55FF;
  localparam logic [c_WORD_W-1:0] c_DEF_TRL = 16'hFFAA;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_TAIL = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/cmd_word_rx.sv
//------------------------------------------------------------------------------
// Module  : cmd_word_rx
// Brief   : Serial-to-16-bit deserializer aligned by a per-word sync pulse.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cmd_word_rx
  import cmd_unpack_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_fs,
  input  logic                i_d,
  output logic [c_WORD_W-1:0] o_word,
  output logic                o_word_vld,
  output logic                o_word_abort
);

  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_WORD_W - 1);

  // r_cnt == 0 means no word in progress; 1..15 is bits already captured
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_WORD_W-1:0] r_sh;
  logic                r_word_vld;
  logic                r_abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_sh       <= '0;
      r_word_vld <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_word_vld <= 1'b0;
      r_abort    <= 1'b0;
      if (i_fs) begin
        r_abort <= (r_cnt != '0);
        r_sh    <= {{(c_WORD_W-1){1'b0}}, i_d};
        r_cnt   <= c_CNT_W'(1);
      end else if (r_cnt != '0) begin
        r_sh <= {r_sh[c_WORD_W-2:0], i_d};
        if (r_cnt == c_LAST) begin
          r_cnt      <= '0;
          r_word_vld <= 1'b1;
        end else begin
          r_cnt <= r_cnt + c_CNT_W'(1);
        end
      end
    end
  end

  // The shift register holds the finished word through the word_vld cycle
  assign o_word       = r_sh;
  assign o_word_vld   = r_word_vld;
  assign o_word_abort = r_abort;

endmodule

`default_nettype wire

// File: rtl/cmd_unpack.sv
//------------------------------------------------------------------------------
// Module  : cmd_unpack
// Brief   : Frames header/hi/lo/trailer words into a held 32-bit command output.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cmd_unpack
  import cmd_unpack_pkg::*;
#(
  parameter logic [c_WORD_W-1:0] P_HDR = c_DEF_HDR,
  parameter logic [c_WORD_W-1:0] P_TRL = c_DEF_TRL
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_fs,
  input  logic               i_d,
  output logic [c_CMD_W-1:0] o_out_data,
  output logic               o_out_vld,
  input  logic               i_out_rdy,
  output logic               o_err,
  output logic               o_ovf
);

  logic [c_WORD_W-1:0] w_word;
  logic                w_word_vld;
  logic                w_word_abort;

  cmd_word_rx u_word_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_fs         (i_fs),
    .i_d          (i_d),
    .o_word       (w_word),
    .o_word_vld   (w_word_vld),
    .o_word_abort (w_word_abort)
  );

  state_t              r_state;
  state_t              w_next;
  logic [c_WORD_W-1:0] r_hi;
  logic [c_WORD_W-1:0] r_lo;
  logic [c_CMD_W-1:0]  r_data;
  logic                r_vld;
  logic                r_err;
  logic                r_ovf;
  logic                w_err;
  logic                w_deliver;
  logic                w_ld_hi;
  logic                w_ld_lo;
  logic                w_accept;
  logic                w_ovf;

  always_comb begin
    w_next    = r_state;
    w_err     = 1'b0;
    w_deliver = 1'b0;
    w_ld_hi   = 1'b0;
    w_ld_lo   = 1'b0;
    if (w_word_abort) begin
      if (r_state != ST_HUNT) begin
        w_err  = 1'b1;
        w_next = ST_HUNT;
      end
    end else if (w_word_vld) begin
      case (r_state)
        ST_HUNT: if (w_word == P_HDR) w_next = ST_HI;
        ST_HI: begin
          w_ld_hi = 1'b1;
          w_next  = ST_LO;
        end
        ST_LO: begin
          w_ld_lo = 1'b1;
          w_next  = ST_TAIL;
        end
        ST_TAIL: begin
          if (w_word == P_TRL) begin
            w_deliver = 1'b1;
            w_next    = ST_HUNT;
          end else begin
            // A bad trailer that is itself a header restarts the frame
            w_err  = 1'b1;
            w_next = (w_word == P_HDR) ? ST_HI : ST_HUNT;
          end
        end
        default: w_next = ST_HUNT;
      endcase
    end
  end

  assign w_accept = r_vld & i_out_rdy;
  assign w_ovf    = w_deliver & r_vld & ~i_out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HUNT;
      r_hi    <= '0;
      r_lo    <= '0;
      r_data  <= '0;
      r_vld   <= 1'b0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_err;
      r_ovf   <= w_ovf;
      if (w_ld_hi) r_hi <= w_word;
      if (w_ld_lo) r_lo <= w_word;
      // Held entry wins over a new frame unless it is being accepted now
      if (w_deliver && (!r_vld || i_out_rdy)) begin
        r_data <= {r_hi, r_lo};
        r_vld  <= 1'b1;
      end else if (w_accept) begin
        r_vld <= 1'b0;
      end
    end
  end

  assign o_out_data = r_data;
  assign o_out_vld  = r_vld;
  assign o_err      = r_err;
  assign o_ovf      = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_cmd_unpack.sv
//------------------------------------------------------------------------------
// Module  : tb_cmd_unpack
// Brief   : Scoreboard bench for cmd_unpack using directed serial frames.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cmd_unpack;

  localparam int c_K_DATA = 0;
  localparam int c_K_ERR  = 1;
  localparam int c_K_OVF  = 2;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        i_fs;
  logic        i_d;
  logic [31:0] o_out_data;
  logic        o_out_vld;
  logic        i_out_rdy;
  logic        o_err;
  logic        o_ovf;

  exp_t q[$];
  int   checks;
  int   errors;

  cmd_unpack dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_fs       (i_fs),
    .i_d        (i_d),
    .o_out_data (o_out_data),
    .o_out_vld  (o_out_vld),
    .i_out_rdy  (i_out_rdy),
    .o_err      (o_err),
    .o_ovf      (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [31:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    q.push_back(e);
  endtask

  task automatic pop_chk(input int kind, input logic [31:0] data, input string name);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event data %h, nothing expected", name, data);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.data !== data) begin
        errors++;
        $display("FAIL %s: got kind %0d data %h expected kind %0d data %h",
                 name, kind, data, e.kind, e.data);
      end
    end
  endtask

  // Monitor: outputs are stable between edges; rdy is held until the next posedge
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (o_err) pop_chk(c_K_ERR, 32'h0, "err_pulse");
      if (o_ovf) pop_chk(c_K_OVF, 32'h0, "ovf_pulse");
      if (o_out_vld && i_out_rdy) pop_chk(c_K_DATA, o_out_data, "out_data");
    end
  end

  task automatic tick();
    @(negedge clk);
    i_fs = 1'b0;
    i_d  = 1'b1;
  endtask

  task automatic send_bits(input logic [15:0] w, input int nbits);
    for (int i = 15; i > 15 - nbits; i--) begin
      @(negedge clk);
      i_fs = (i == 15);
      i_d  = w[i];
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    send_bits(w, 16);
  endtask

  task automatic send_frame(input logic [15:0] hi, input logic [15:0] lo);
    send_word(16'h55FF);
    send_word(hi);
    send_word(lo);
    send_word(16'hFFAA);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    i_fs      = 1'b0;
    i_d       = 1'b0;
    i_out_rdy = 1'b1;
    repeat (3) tick();
    chk("reset_vld", {31'h0, o_out_vld}, 32'h0);
    chk("reset_data", o_out_data, 32'h0);
    chk("reset_err_ovf", {30'h0, o_err, o_ovf}, 32'h0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic frame, with explicit trailer-to-valid latency
    expect_ev(c_K_DATA, 32'h1234ABCD);
    send_frame(16'h1234, 16'hABCD);
    tick();
    chk("lat_word_cycle_vld", {31'h0, o_out_vld}, 32'h0);
    tick();
    chk("lat_vld_high", {31'h0, o_out_vld}, 32'h1);
    chk("lat_data", o_out_data, 32'h1234ABCD);
    chk("lat_no_err", {31'h0, o_err}, 32'h0);
    tick();
    chk("lat_vld_drop", {31'h0, o_out_vld}, 32'h0);
    repeat (3) tick();

    // Delimiter values as payload, back-to-back after a non-header word in HUNT
    expect_ev(c_K_DATA, 32'h55FFFFAA);
    send_word(16'h1234);
    send_frame(16'h55FF, 16'hFFAA);
    repeat (4) tick();

    // Header in trailer slot restarts the frame
    expect_ev(c_K_ERR, 32'h0);
    expect_ev(c_K_DATA, 32'h00030004);
    send_word(16'h55FF);
    send_word(16'h0001);
    send_word(16'h0002);
    send_word(16'h55FF);
    send_word(16'h0003);
    send_word(16'h0004);
    send_word(16'hFFAA);
    repeat (4) tick();

    // Sync reasserted mid hi word aborts the frame
    expect_ev(c_K_ERR, 32'h0);
    expect_ev(c_K_DATA, 32'hCAFEBEEF);
    send_word(16'h55FF);
    send_bits(16'h1234, 7);
    send_word(16'h0000);
    send_frame(16'hCAFE, 16'hBEEF);
    repeat (4) tick();

    // Output held while not ready: second frame dropped with overflow
    i_out_rdy = 1'b0;
    expect_ev(c_K_OVF, 32'h0);
    expect_ev(c_K_DATA, 32'h11112222);
    send_frame(16'h1111, 16'h2222);
    send_frame(16'h3333, 16'h4444);
    repeat (3) tick();
    chk("hold_vld", {31'h0, o_out_vld}, 32'h1);
    chk("hold_data", o_out_data, 32'h11112222);
    tick();
    i_out_rdy = 1'b1;
    tick();
    chk("accept_vld_drop", {31'h0, o_out_vld}, 32'h0);
    repeat (2) tick();

    // Reset mid-frame discards state; stray trailer must do nothing
    send_word(16'h55FF);
    send_word(16'h1234);
    send_word(16'h5678);
    tick();
    rst_n = 1'b0;
    #1;
    chk("async_rst_data", o_out_data, 32'h0);
    chk("async_rst_vld", {31'h0, o_out_vld}, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    send_word(16'hFFAA);
    repeat (4) tick();
    chk("post_rst_no_vld", {31'h0, o_out_vld}, 32'h0);
    expect_ev(c_K_DATA, 32'h0BADF00D);
    send_frame(16'h0BAD, 16'hF00D);
    repeat (5) tick();

    chk("scoreboard_empty", q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cmd_unpack.md
CMD_UNPACK -- requirements
Module: cmd_unpack

Interface
REQ-001 Parameter P_HDR, 16'h55FF, frame header word.
REQ-002 Parameter P_TRL, 16'hFFAA, frame trailer word.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 i_fs  input  1  word sync; high for one clk coincident with MSB of each 16-bit word.
REQ-006 i_d  input  1  serial data; one bit per clk, MSB first.
REQ-007 o_out_data  output  32  unpacked command {hi word, lo word}.
REQ-008 o_out_vld  output  1  o_out_data valid.
REQ-009 i_out_rdy  input  1  downstream ready.
REQ-010 o_err  output  1  one-clk pulse on framing error.
REQ-011 o_ovf  output  1  one-clk pulse when a good frame is dropped because the output is still held.

Function
REQ-012 Serial format: bit 15 sampled on the clk where i_fs=1; bits 14..0 on the next 15 clks; word complete after the 16th bit.
REQ-013 Deserializer SHALL assert word_vld for one clk, the cycle after the 16th bit is sampled, with the 16-bit word.
REQ-014 Bits received with no word in progress and i_fs=0 SHALL be ignored.
REQ-015 i_fs=1 while a word is in progress (bit count 1..15) SHALL discard the partial word, start a new word at this bit, and raise word_abort for one clk.
REQ-016 Back-to-back words (i_fs on the clk after a word's 16th bit) SHALL be received without loss.
REQ-017 Frame FSM states: HUNT, HI, LO, TAIL; reset state HUNT.
REQ-018 HUNT: word==P_HDR -> HI; any other word -> stay HUNT, no error.
REQ-019 HI: any word -> latch as data[31:16], go LO (P_HDR/P_TRL values are legal data).
REQ-020 LO: any word -> latch as data[15:0], go TAIL.
REQ-021 TAIL: word==P_TRL -> deliver frame, go HUNT; otherwise pulse o_err and go HI if word==P_HDR, else HUNT.
REQ-022 word_abort in HI, LO or TAIL SHALL pulse o_err and go HUNT; in HUNT it SHALL be ignored.
REQ-023 Delivery: o_out_data/o_out_vld updated on the clk after the trailer word_vld (trailer-to-vld latency 1 clk).
REQ-024 o_out_vld held with o_out_data stable until i_out_rdy=1 sampled; vld drops the next clk unless a new delivery coincides.
REQ-025 Delivery on the same clk that the held entry is accepted (vld&rdy) SHALL load the new frame with vld kept high.
REQ-026 Delivery while vld=1 and rdy=0 SHALL drop the new frame, keep the old one, and pulse o_ovf.
REQ-027 Partially collected hi/lo words SHALL never reach o_out_data.

Reset
REQ-028 rst_n low SHALL immediately force FSM=HUNT, bit count=0, o_out_vld=0, o_err=0, o_ovf=0, o_out_data=32'h0.
REQ-029 Reset mid-word or mid-frame SHALL discard all partial state; the first frame after release needs a fresh i_fs-aligned header.

Structure
REQ-030 Shared package: FSM state encoding, default header/trailer constants (shared with transmit-side packer), word width 16, command width 32.
REQ-031 One sub-module, cmd_word_rx: serial-to-16-bit deserializer (i_fs, i_d -> word, word_vld, word_abort); cmd_unpack holds the frame FSM and output register.

Verification
REQ-032 Frame 55FF,1234,ABCD,FFAA, rdy=1 -> o_out_data=32'h1234ABCD, vld one clk, 1 clk after trailer word complete; o_err=0.
REQ-033 Frame 55FF,55FF,FFAA,FFAA -> o_out_data=32'h55FFFFAA delivered, no error.
REQ-034 55FF,0001,0002,55FF,0003,0004,FFAA -> o_err pulse at 4th word, then 32'h00030004 delivered.
REQ-035 i_fs reasserted at bit 7 of hi word -> o_err pulse, FSM HUNT; following good frame 55FF,CAFE,BEEF,FFAA delivers 32'hCAFEBEEF.
REQ-036 rdy=0, two good frames back-to-back -> first frame held on o_out_data, o_ovf pulse at second trailer; rdy=1 -> first frame accepted, vld drops.
REQ-037 rst_n asserted after the lo word, released, trailer FFAA sent -> no delivery, no error; next full frame delivered.
